// File: rtl/writeback_sequencer_if.sv
// Data-memory handshake between the writeback sequencer (master) and the
// variable-latency data memory (slave).
interface writeback_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/writeback_sequencer.sv
// RV32I writeback sequencer: single-cycle pass-through for non-memory
// instructions, stretched load/store handshake with timeout for memory ones.
module writeback_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [1:0]            ResultSrc_in,
    input  logic                  RegWrite_in,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [4:0]            Rd_in,
    writeback_sequencer_if.master mem,
    output logic [1:0]            ResultSrc,
    output logic                  RegWrite,
    output logic [4:0]            Rd,
    output logic [31:0]           RD_q,
    output logic                  stall,
    output logic                  mem_fault
);

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        WB
    } state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [4:0]  rd_l;
    logic        regwrite_l;
    logic        load_l;
    logic        aborted_l;
    logic        mem_op;

    assign mem_op = instr_valid & (MemRead | MemWrite);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            rd_l       <= '0;
            regwrite_l <= 1'b0;
            load_l     <= 1'b0;
            aborted_l  <= 1'b0;
            RD_q       <= '0;
            mem_fault  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_op) begin
                        rd_l       <= Rd_in;
                        regwrite_l <= RegWrite_in;
                        // Load takes priority when both MemRead and MemWrite are set
                        load_l     <= MemRead;
                        aborted_l  <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem.mem_ready) begin
                        if (load_l) begin
                            RD_q <= mem.mem_rdata;
                        end
                        state <= WB;
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem_fault <= 1'b1;
                        aborted_l <= 1'b1;
                        state     <= WB;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode from the registered state; IDLE passes decode straight through
    always_comb begin
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        stall       = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 2'b00;
        Rd          = Rd_in;
        unique case (state)
            IDLE: begin
                if (mem_op) begin
                    mem.mem_req = 1'b1;
                    mem.mem_we  = MemWrite & ~MemRead;
                    stall       = 1'b1;
                    ResultSrc   = 2'b01;
                end else if (instr_valid) begin
                    ResultSrc = ResultSrc_in;
                    RegWrite  = RegWrite_in;
                end
            end
            MEM_WAIT: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = ~load_l;
                stall       = 1'b1;
                ResultSrc   = 2'b01;
                Rd          = rd_l;
            end
            WB: begin
                ResultSrc = 2'b01;
                Rd        = rd_l;
                RegWrite  = regwrite_l & load_l & ~aborted_l;
            end
            default: begin
                mem.mem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/writeback_sequencer.md
# writeback_sequencer

Multi-cycle sequencer for the register-file writeback path and data-memory access of the RV32I core. It drives the writeback result-select (`ResultSrc`) and `RegWrite` into the result multiplexer. Non-memory instructions complete in one cycle; loads and stores are stretched over a ready/request handshake with a variable-latency data memory. While memory is pending it stalls the PC, captures load data into a register that feeds the mux `RD` input, and enforces a timeout.

## Interface
- `TIMEOUT`, 255: maximum number of MEM_WAIT cycles before the access is abandoned; legal range 2..65535.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: current instruction from decode is valid.
- `ResultSrc_in` in 2: decoder result select (00 ALU, 01 memory, 10 PC+4).
- `RegWrite_in` in 1: decoder register-write enable.
- `MemRead` in 1: instruction is a load.
- `MemWrite` in 1: instruction is a store.
- `Rd_in` in 5: destination register index.
- `mem_ready` in 1: data memory completes the access this cycle.
- `mem_rdata` in 32: load data, valid when `mem_ready`=1.
- `mem_req` out 1: access request; held high until the access completes.
- `mem_we` out 1: write request; stable whenever `mem_req`=1.
- `ResultSrc` out 2: select into the result multiplexer.
- `RegWrite` out 1: register-file write enable.
- `Rd` out 5: register-file write index.
- `RD_q` out 32: registered load data; drives the mux `RD` input.
- `stall` out 1: hold PC and the fetched instruction.
- `mem_fault` out 1: sticky timeout flag.

## Operation
States:
- **IDLE**
  - Non-memory instruction (`instr_valid`=1, `MemRead`=`MemWrite`=0): combinational pass-through. `ResultSrc`=`ResultSrc_in`, `RegWrite`=`RegWrite_in`, `Rd`=`Rd_in`, `stall`=0, `mem_req`=0. Stay in IDLE.
  - `instr_valid`=0: `ResultSrc`=00, `RegWrite`=0, `stall`=0, `mem_req`=0.
  - Memory instruction (`MemRead` or `MemWrite` set, with `instr_valid`): `mem_req`=1, `stall`=1, `RegWrite`=0, `ResultSrc`=01.
    - Latch `Rd_in`, `RegWrite_in` and op type.
    - `mem_we`=`MemWrite` & !`MemRead`. If both are set, the instruction is treated as a load.
    - Clear the wait counter. Next state is MEM_WAIT.
  - `mem_ready` is ignored in IDLE.
- **MEM_WAIT**
  - Outputs: `mem_req`=1, `mem_we` from the latched op, `stall`=1, `RegWrite`=0, `ResultSrc`=01, `Rd`=latched.
  - `mem_ready`=1:
    - Load: `RD_q`<=`mem_rdata`.
    - Next state is WB.
  - No `mem_ready` and counter==`TIMEOUT`-1: `mem_fault`<=1, mark access aborted, next state is WB.
  - Otherwise: counter+1, stay in MEM_WAIT.
  - If `mem_ready` arrives in the same cycle as the timeout, `mem_ready` wins and no fault is raised.
- **WB**
  - Outputs: `mem_req`=0, `stall`=0 (PC advances at the end of this cycle), `ResultSrc`=01, `Rd`=latched.
  - `RegWrite`=latched `RegWrite_in` & load & !aborted.
  - `instr_valid` is ignored, because the fetched instruction is still the memory instruction.
  - Next state is IDLE.

Width rules:
- Wait counter is 16 bits; it only increments while in MEM_WAIT.
- `RD_q` is updated only by a completed load. Stores and aborted accesses leave it unchanged.
- `mem_fault` is cleared only by reset.

## Timing
Reset (`rst_n`=0, asynchronous, any state including mid-access):
- Registered state: state=IDLE, counter=0, `RD_q`=0, latched `Rd`/op=0, `mem_fault`=0.
- Outputs take IDLE values immediately: `mem_req`=0, `mem_we`=0, `stall`=0, and with `instr_valid`=0, `RegWrite`=0 and `ResultSrc`=00.

Latency:
- Non-memory instruction: 0 cycles, 1 cycle per instruction.
- Load or store with `mem_ready` in MEM_WAIT cycle k (k≥1): total k+2 cycles. `stall`=1 for k+1 cycles; write occurs in the WB cycle.
- Minimum memory op is 3 cycles. Maximum is `TIMEOUT`+2 cycles.

Back-to-back operation:
- After WB, the next instruction is evaluated in IDLE on the following cycle.
- There are no bubbles between consecutive non-memory instructions.

## Test plan
- **Reset mid-access:** assert `rst_n`=0 during MEM_WAIT → same cycle `mem_req`=0 and `stall`=0; `mem_fault`=0 and `RD_q`=0 after release.
- **ALU and JAL pass-through:** `instr_valid`=1, `ResultSrc_in`=00, `RegWrite_in`=1, `Rd_in`=5 → `RegWrite`=1, `ResultSrc`=00, `Rd`=5, `stall`=0. Then `ResultSrc_in`=10, `Rd_in`=1 → `ResultSrc`=10, `Rd`=1.
- **Load, ready in 3rd MEM_WAIT cycle:** `MemRead`=1, `Rd_in`=7, `mem_rdata`=0xDEADBEEF → `stall`=1 for 4 cycles, `mem_req` high for 4 cycles. WB cycle: `RegWrite`=1, `ResultSrc`=01, `Rd`=7, `RD_q`=0xDEADBEEF, `stall`=0.
- **Store, ready in 1st MEM_WAIT cycle:** `mem_we`=1 for 2 cycles → WB has `RegWrite`=0, `RD_q` unchanged, `stall`=0 in WB.
- **Timeout with `TIMEOUT`=4:**
  - `mem_ready` never asserted → `mem_fault`=1 after 4 MEM_WAIT cycles; WB has `RegWrite`=0; `RD_q` unchanged; fault persists across later instructions.
  - Rerun with `mem_ready` in the 4th MEM_WAIT cycle → `mem_fault`=0 and the write occurs.
- **Mixed sequence:** load (ready in 1st wait cycle), then ALU, then load → ALU `RegWrite` occurs on the cycle right after the first WB; `mem_ready` pulses while in IDLE are ignored.
